// File: rtl/store_aligner.sv
// store_aligner: turns a right-justified RISC-V store (SB/SH/SW/SD) into one or two
// lane-positioned memory beats with a per-bit write mask.
//
// Optional feature: define STORE_ALIGNER_SPLIT_EN to serve stores that cross an XLEN/8-byte
// boundary as two back-to-back beats. Without it, crossing stores are rejected exactly like
// illegal sizes (one-cycle store_err pulse, no beat).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready store request handshake (ready only while idle)
//   req_addr            byte address of the store
//   req_funct3          store size: 000 SB, 001 SH, 010 SW, 011 SD (SD only when XLEN = 64)
//   req_data            store data, right-justified
//   mem_valid/mem_ready memory beat handshake
//   mem_addr            word-aligned beat address
//   mem_wdata           lane-positioned write data, zero in disabled lanes
//   mem_wbits           per-bit write enable, whole bytes
//   store_err           one-cycle pulse after a rejected request
module store_aligner #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_wbits,
  output logic              store_err
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam logic [ADDR_W-1:0] NbAddr = ADDR_W'(NB);

`ifdef STORE_ALIGNER_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]   mem_wbits_q, mem_wbits_d;
  logic [XLEN-1:0]   hi_wdata_q, hi_wdata_d;
  logic [XLEN-1:0]   hi_wbits_q, hi_wbits_d;
  logic              split_q, split_d;
  logic              store_err_q, store_err_d;

  logic [OW-1:0]     offset;
  logic [3:0]        size;
  logic              legal_f3;
  logic              crossing;
  logic              accept_ok;
  logic [XLEN-1:0]   size_mask;
  logic [2*XLEN-1:0] data_wide;
  logic [2*XLEN-1:0] bits_wide;

  assign offset = req_addr[OW-1:0];

  always_comb begin
    size     = 4'd1;
    legal_f3 = 1'b0;
    case (req_funct3)
      3'b000:  begin size = 4'd1; legal_f3 = 1'b1; end
      3'b001:  begin size = 4'd2; legal_f3 = 1'b1; end
      3'b010:  begin size = 4'd4; legal_f3 = 1'b1; end
      3'b011:  begin size = 4'd8; legal_f3 = (XLEN == 64); end
      default: begin size = 4'd1; legal_f3 = 1'b0; end
    endcase
  end

  always_comb begin
    size_mask = '0;
    for (int b = 0; b < int'(XLEN); b++) begin
      size_mask[b] = (b / 8) < int'(size);
    end
  end

  // Shifting into a double-width vector gives beat 0 in the low half and the spill-over
  // for beat 1 (data >> 8*(NB-O)) in the high half.
  assign data_wide = {{XLEN{1'b0}}, req_data & size_mask} << {offset, 3'b000};
  assign bits_wide = {{XLEN{1'b0}}, size_mask} << {offset, 3'b000};

  assign crossing  = (32'(offset) + 32'(size)) > NB;
  assign accept_ok = legal_f3 && (!crossing || SplitEn);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wbits_d = mem_wbits_q;
    hi_wdata_d  = hi_wdata_q;
    hi_wbits_d  = hi_wbits_q;
    split_d     = split_q;
    store_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (!accept_ok) begin
            store_err_d = 1'b1;
          end else begin
            state_d     = StBeat0;
            mem_addr_d  = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
            mem_wdata_d = data_wide[XLEN-1:0];
            mem_wbits_d = bits_wide[XLEN-1:0];
            hi_wdata_d  = data_wide[2*XLEN-1:XLEN];
            hi_wbits_d  = bits_wide[2*XLEN-1:XLEN];
            split_d     = crossing;
          end
        end
      end
      StBeat0: begin
        if (mem_ready) begin
          if (split_q && SplitEn) begin
            state_d     = StBeat1;
            mem_addr_d  = mem_addr_q + NbAddr;
            mem_wdata_d = hi_wdata_q;
            mem_wbits_d = hi_wbits_q;
          end else begin
            state_d     = StIdle;
            mem_wdata_d = '0;
            mem_wbits_d = '0;
          end
        end
      end
      StBeat1: begin
        if (mem_ready) begin
          state_d     = StIdle;
          mem_wdata_d = '0;
          mem_wbits_d = '0;
        end
      end
      default: begin
        state_d     = StIdle;
        mem_wdata_d = '0;
        mem_wbits_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wbits_q <= '0;
      hi_wdata_q  <= '0;
      hi_wbits_q  <= '0;
      split_q     <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wbits_q <= mem_wbits_d;
      hi_wdata_q  <= hi_wdata_d;
      hi_wbits_q  <= hi_wbits_d;
      split_q     <= split_d;
      store_err_q <= store_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_valid = (state_q != StIdle);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wbits = mem_wbits_q;
  assign store_err = store_err_q;

endmodule

// File: tb/tb_store_aligner.sv
// Bench for store_aligner: one XLEN=32 and one XLEN=64 instance, directed cases followed
// by random stores, each compared against a byte-address model of the store.
module tb_store_aligner;

`ifdef STORE_ALIGNER_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_data = '0;
  logic        mem_ready = 1'b0;

  logic        rv32, rv64;
  logic        rdy32, rdy64, val32, val64, err32, err64;
  logic [31:0] addr32, addr64;
  logic [31:0] wd32, wb32;
  logic [63:0] wd64, wb64;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_addr;
  logic [63:0] o_wd, o_wb;

  int checks = 0;
  int errors = 0;

  int          exp_n;
  logic [31:0] exp_addr [2];
  logic [63:0] exp_wd [2];
  logic [63:0] exp_wb [2];

  always #5 clk = ~clk;

  assign rv32 = req_valid & ~sel;
  assign rv64 = req_valid & sel;

  store_aligner #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv32), .req_ready(rdy32), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_data(req_data[31:0]), .mem_valid(val32),
    .mem_ready(mem_ready), .mem_addr(addr32), .mem_wdata(wd32), .mem_wbits(wb32),
    .store_err(err32)
  );

  store_aligner #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv64), .req_ready(rdy64), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_data(req_data), .mem_valid(val64),
    .mem_ready(mem_ready), .mem_addr(addr64), .mem_wdata(wd64), .mem_wbits(wb64),
    .store_err(err64)
  );

  always_comb begin
    o_ready = sel ? rdy64 : rdy32;
    o_valid = sel ? val64 : val32;
    o_err   = sel ? err64 : err32;
    o_addr  = sel ? addr64 : addr32;
    o_wd    = sel ? wd64 : {32'b0, wd32};
    o_wb    = sel ? wb64 : {32'b0, wb32};
  end

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Places each store byte at its absolute byte address, then groups bytes by memory word.
  task automatic model(input logic [31:0] a, input logic [2:0] f3, input logic [63:0] d,
                       input int nb);
    int          s;
    int          lane;
    int          beat;
    logic [31:0] ab;
    logic [31:0] nb32;
    logic [31:0] base0;
    nb32 = 32'(nb);
    for (int k = 0; k < 2; k++) begin
      exp_addr[k] = '0;
      exp_wd[k]   = '0;
      exp_wb[k]   = '0;
    end
    case (f3)
      3'd0:    s = 1;
      3'd1:    s = 2;
      3'd2:    s = 4;
      3'd3:    s = 8;
      default: s = 0;
    endcase
    if (s == 0 || s > nb) begin
      exp_n = 0;
    end else begin
      exp_n = 1;
      base0 = a - (a % nb32);
      for (int i = 0; i < s; i++) begin
        ab   = a + 32'(i);
        lane = int'(ab % nb32);
        beat = ((ab - (ab % nb32)) != base0) ? 1 : 0;
        if (beat == 1) exp_n = 2;
        exp_addr[beat]              = ab - (ab % nb32);
        exp_wd[beat][8*lane +: 8]   = d[8*i +: 8];
        exp_wb[beat][8*lane +: 8]   = 8'hFF;
      end
      if (exp_n == 2 && !SPLIT) exp_n = 0;
    end
  endtask

  task automatic run(input bit s64, input logic [31:0] a, input logic [2:0] f3,
                     input logic [63:0] d, input int stall);
    model(a, f3, d, s64 ? 8 : 4);
    @(negedge clk);
    sel        = s64;
    req_valid  = 1'b1;
    req_addr   = a;
    req_funct3 = f3;
    req_data   = s64 ? d : {32'b0, d[31:0]};
    mem_ready  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_n == 0) begin
      chk(64'(o_err), 64'd1, "err_pulse");
      chk(64'(o_valid), 64'd0, "err_no_beat");
      chk(64'(o_ready), 64'd1, "err_ready");
      @(negedge clk);
      chk(64'(o_err), 64'd0, "err_one_cycle");
      chk(64'(o_valid), 64'd0, "err_still_no_beat");
    end else begin
      chk(64'(o_err), 64'd0, "no_err");
      for (int b = 0; b < exp_n; b++) begin
        for (int k = 0; k <= stall; k++) begin
          chk(64'(o_valid), 64'd1, "beat_valid");
          chk(64'(o_ready), 64'd0, "beat_not_ready");
          chk(64'(o_addr), 64'(exp_addr[b]), "beat_addr");
          chk(o_wd, exp_wd[b], "beat_wdata");
          chk(o_wb, exp_wb[b], "beat_wbits");
          if (k == stall) mem_ready = 1'b1;
          @(negedge clk);
        end
        mem_ready = 1'b0;
      end
      chk(64'(o_valid), 64'd0, "done_idle");
      chk(o_wd, 64'd0, "done_wdata_zero");
      chk(o_wb, 64'd0, "done_wbits_zero");
      chk(64'(o_ready), 64'd1, "done_ready");
    end
  endtask

  initial begin
    #1;
    chk(64'(val32), 64'd0, "rst_valid32");
    chk(64'(rdy32), 64'd1, "rst_ready32");
    chk(64'(addr32), 64'd0, "rst_addr32");
    chk(64'(wd32), 64'd0, "rst_wdata32");
    chk(64'(wb32), 64'd0, "rst_wbits32");
    chk(64'(err32), 64'd0, "rst_err32");
    chk(64'(val64), 64'd0, "rst_valid64");
    chk(wb64, 64'd0, "rst_wbits64");
    @(negedge clk);
    rst_n = 1'b1;

    run(1'b0, 32'h0000_1003, 3'b000, 64'h0000_00A5, 0);
    run(1'b0, 32'h0000_2002, 3'b010, 64'h1122_3344, 0);
    run(1'b0, 32'h0000_3000, 3'b001, 64'h0000_BEEF, 3);
    run(1'b0, 32'h0000_4000, 3'b011, 64'h1234_5678, 0);
    run(1'b0, 32'h0000_4001, 3'b101, 64'h1234_5678, 0);
    run(1'b0, 32'h0000_4003, 3'b001, 64'h0000_5AA5, 2);
    run(1'b0, 32'hFFFF_FFFE, 3'b010, 64'hCAFE_F00D, 1);
    run(1'b1, 32'h0000_0008, 3'b011, 64'h0123_4567_89AB_CDEF, 0);
    run(1'b1, 32'h0000_000C, 3'b011, 64'h0123_4567_89AB_CDEF, 1);
    run(1'b1, 32'h0000_0105, 3'b010, 64'hDEAD_BEEF, 0);
    run(1'b1, 32'h0000_0107, 3'b111, 64'hDEAD_BEEF, 0);

    for (int n = 0; n < 60; n++) begin
      run(1'($urandom_range(1)), $urandom, 3'($urandom_range(7)),
          {$urandom, $urandom}, int'($urandom_range(2)));
    end

    // Reset while a beat is stalled (the second beat when split support is built in).
    @(negedge clk);
    sel        = 1'b0;
    req_valid  = 1'b1;
    req_addr   = SPLIT ? 32'h0000_2002 : 32'h0000_3000;
    req_funct3 = SPLIT ? 3'b010 : 3'b001;
    req_data   = 64'h1122_3344;
    mem_ready  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    if (SPLIT) begin
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    chk(64'(val32), 64'd1, "pre_rst_valid");
    #2 rst_n = 1'b0;
    #1;
    chk(64'(val32), 64'd0, "midrst_valid");
    chk(64'(rdy32), 64'd1, "midrst_ready");
    chk(64'(addr32), 64'd0, "midrst_addr");
    chk(64'(wd32), 64'd0, "midrst_wdata");
    chk(64'(wb32), 64'd0, "midrst_wbits");
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(64'(val32), 64'd0, "postrst_no_beat");
      chk(64'(rdy32), 64'd1, "postrst_ready");
    end
    mem_ready = 1'b0;
    run(1'b0, 32'h0000_1001, 3'b001, 64'h0000_A55A, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_aligner.md
STORE_ALIGNER -- requirements
Module: store_aligner

Interface
REQ-001 SHALL have parameter XLEN, default 32, memory data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  store request present.
REQ-006 SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port req_addr  input  ADDR_W  byte address of store.
REQ-008 SHALL have port req_funct3  input  3  store size: 000 SB, 001 SH, 010 SW, 011 SD.
REQ-009 SHALL have port req_data  input  XLEN  store data, right-justified.
REQ-010 SHALL have port mem_valid  output  1  memory beat present.
REQ-011 SHALL have port mem_ready  input  1  memory accepts beat.
REQ-012 SHALL have port mem_addr  output  ADDR_W  word-aligned beat address; low log2(XLEN/8) bits always 0.
REQ-013 SHALL have port mem_wdata  output  XLEN  lane-positioned write data; disabled lanes 0.
REQ-014 SHALL have port mem_wbits  output  XLEN  per-bit write mask; 1 = write bit, set in whole bytes.
REQ-015 SHALL have port store_err  output  1  one-cycle pulse on rejected request.

Function
REQ-016 SHALL implement states IDLE, BEAT0, BEAT1; req_ready = 1 exactly in IDLE.
REQ-017 SHALL accept a request on req_valid && req_ready, registering addr, funct3, data.
REQ-018 SHALL compute size S = 1/2/4/8 bytes from funct3, offset O = addr mod (XLEN/8), NB = XLEN/8.
REQ-019 SHALL treat funct3 other than 000-010 (plus 011 when XLEN=64) as illegal: no beat, store_err = 1 in the following cycle, stay IDLE.
REQ-020 SHALL, for legal request with O+S <= NB, enter BEAT0 as single beat: mem_addr = addr with low bits cleared, mem_wdata = data[8S-1:0] << 8*O, mem_wbits bytes O..O+S-1 set.
REQ-021 SHALL, for legal request with O+S > NB (crossing), behave per Configuration.
REQ-022 SHALL assert mem_valid the cycle after acceptance (latency 1).
REQ-023 SHALL hold mem_valid, mem_addr, mem_wdata, mem_wbits stable while mem_valid && !mem_ready.
REQ-024 SHALL on BEAT0 handshake return to IDLE (single) or enter BEAT1 (split) with mem_valid remaining 1, no bubble.
REQ-025 SHALL drive BEAT1: mem_addr = BEAT0 address + NB (wraps modulo 2^ADDR_W), mem_wdata = data >> 8*(NB-O) in low lanes, mem_wbits bytes 0..O+S-NB-1 set.
REQ-026 SHALL on BEAT1 handshake return to IDLE; next request acceptable that cycle+1.
REQ-027 SHALL drive mem_wdata and mem_wbits to 0 whenever mem_valid = 0.
REQ-028 SHALL ignore req_valid outside IDLE; requester holds request until req_ready.

Reset
REQ-029 SHALL on rst_n = 0 immediately force IDLE, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wbits 0, store_err 0, req_ready 1.
REQ-030 SHALL abandon any in-flight beat on reset mid-operation; no beat resumes after release.

Configuration
REQ-031 SHALL compile split support only when macro STORE_ALIGNER_SPLIT_EN is defined.
REQ-032 SHALL with STORE_ALIGNER_SPLIT_EN defined, serve crossing requests as BEAT0 then BEAT1.
REQ-033 SHALL without STORE_ALIGNER_SPLIT_EN, reject crossing requests as REQ-019 (store_err pulse, no beat) and never enter BEAT1.

Verification
REQ-034 SB addr 0x1003 data 0x000000A5, mem_ready=1 -> one beat: mem_addr 0x1000, wdata 0xA5000000, wbits 0xFF000000, then IDLE.
REQ-035 SPLIT_EN, SW addr 0x2002 data 0x11223344 -> beat0 0x2000/0x33440000/0xFFFF0000, beat1 0x2004/0x00001122/0x0000FFFF, back-to-back.
REQ-036 No SPLIT_EN, same request as REQ-035 -> store_err high one cycle, mem_valid stays 0, req_ready stays 1.
REQ-037 SH addr 0x3000 data 0xBEEF, mem_ready low 3 cycles -> mem outputs constant 0x3000/0x0000BEEF/0x0000FFFF, req_ready 0 throughout, beat completes on 4th cycle.
REQ-038 XLEN=32, funct3 011 -> store_err pulse, no beat; XLEN=64 SD addr 0x8 data 0x0123456789ABCDEF -> one beat, wbits all ones.
REQ-039 SPLIT_EN, rst_n low while BEAT1 stalled -> mem_valid 0 same cycle, IDLE after release, no residual beat.
